rgb_fade_sequencer: RTL

//   Central sequencer for the RGB fade datapath. A single timebase walks a
//   6-sextant colour wheel and emits the three duty values that drive the
//   per-channel pwm instances. It replaces three free-running per-channel

---
 rtl/rgb_fade_pkg.sv | 27 ++
 rtl/step_timer.sv | 25 ++
 rtl/rgb_fade_sequencer.sv | 76 +++++++
 3 files changed

// File: rtl/rgb_fade_pkg.sv
// Shared types and the colour-wheel phase table for the RGB fade sequencer.
// Each sextant gives every channel one of four phases; phase_value maps it to a duty.
package rgb_fade_pkg;

  typedef enum logic [1:0] {PH_LOW, PH_INC, PH_HIGH, PH_DEC} phase_t;

  // Rows are sextants 0..5, columns are R, G, B.
  localparam phase_t SEXTANT_PHASE [6][3] = '{
    '{PH_HIGH, PH_INC,  PH_LOW },
    '{PH_DEC,  PH_HIGH, PH_LOW },
    '{PH_LOW,  PH_HIGH, PH_INC },
    '{PH_LOW,  PH_DEC,  PH_HIGH},
    '{PH_INC,  PH_LOW,  PH_HIGH},
    '{PH_HIGH, PH_LOW,  PH_DEC }
  };

  function automatic logic [31:0] phase_value(phase_t ph, logic [31:0] ramp,
                                              logic [31:0] interval);
    case (ph)
      PH_LOW:  return 32'd0;
      PH_INC:  return ramp;
      PH_HIGH: return interval;
      default: return interval - ramp;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Ramp-step prescaler: o_step_tick fires on the last count of each STEP_CLKS window.
// Counting stops entirely while i_en is low.
module step_timer #(
  parameter int STEP_CLKS = 1666
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_step_tick
);

  localparam int PW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

  logic [PW-1:0] r_presc;

  assign o_step_tick = i_en && (r_presc == PW'(STEP_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_presc <= '0;
    else if (i_en)
      r_presc <= o_step_tick ? '0 : r_presc + PW'(1);
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Phase-locked RGB colour-wheel sequencer: one ramp/sextant timebase drives all
// three channel duties, which are published to the PWMs only on period boundaries.
module rgb_fade_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CLKS    = 1666,
  localparam int DW          = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_period_start,
  output logic [DW-1:0] o_duty_r,
  output logic [DW-1:0] o_duty_g,
  output logic [DW-1:0] o_duty_b,
  output logic [2:0]    o_sextant,
  output logic          o_cycle_done
);

  import rgb_fade_pkg::*;

  logic                 w_step_tick;
  logic [2:0][DW-1:0]   w_table;
  logic [DW-1:0]        r_ramp;
  logic [2:0]           r_sextant;
  logic                 r_cycle_done;
  logic [2:0][DW-1:0]   r_live;
  logic [2:0][DW-1:0]   r_duty;

  step_timer #(.STEP_CLKS(STEP_CLKS)) u_step_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .o_step_tick (w_step_tick)
  );

  // Index 0 = R, 1 = G, 2 = B.
  always_comb begin
    for (int c = 0; c < 3; c++)
      w_table[c] = DW'(phase_value(SEXTANT_PHASE[r_sextant][c], 32'(r_ramp),
                                   32'(PWM_INTERVAL)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp       <= '0;
      r_sextant    <= '0;
      r_cycle_done <= 1'b0;
      r_live       <= {DW'(0), DW'(0), DW'(PWM_INTERVAL)};
      r_duty       <= {DW'(0), DW'(0), DW'(PWM_INTERVAL)};
    end else begin
      r_cycle_done <= 1'b0;
      if (w_step_tick) begin
        if (r_ramp == DW'(PWM_INTERVAL - 1)) begin
          r_ramp       <= '0;
          r_sextant    <= (r_sextant == 3'd5) ? 3'd0 : r_sextant + 3'd1;
          r_cycle_done <= (r_sextant == 3'd5);
        end else begin
          r_ramp <= r_ramp + DW'(1);
        end
      end
      // Tracking the table every cycle keeps live duties one cycle behind ramp/sextant;
      // with en low those are frozen, so live stays frozen too.
      r_live <= w_table;
      // Non-blocking load captures the pre-update live value on a coincident strobe.
      if (i_period_start)
        r_duty <= r_live;
    end
  end

  assign o_duty_r     = r_duty[0];
  assign o_duty_g     = r_duty[1];
  assign o_duty_b     = r_duty[2];
  assign o_sextant    = r_sextant;
  assign o_cycle_done = r_cycle_done;

endmodule
